seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle, parametrised ALU for the bus datapath. It latches operands and a one-hot opcode on a start handshake and executes single-cycle logic, shift and rotate operations. Signed multiply and divide run iteratively. It returns a registered double-width {HI, LO} result with a done pulse. It replaces the purely combinational ALU and adds shifts, rotates, negate/not, divide-by-zero and illegal-opcode reporting.

## Interface
- `BITS`, 32, operand width; must be even and ≥ 4.
- `SIG_COUNT`, 12, one-hot opcode width; fixed encoding below.
- `SHAMT_W`, $clog2(BITS), width of shift/rotate amount taken from `Y`.

- `clk`  in  1  clock; all state updates on rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `ctrl_signal`  in  SIG_COUNT  one-hot opcode: 0 add, 1 sub, 2 mul, 3 div, 4 shr, 5 shl, 6 ror, 7 rol, 8 and, 9 or, 10 neg, 11 not.
- `X`, `Y`  in  BITS  operands; sampled only on accept.
- `operationResult`  out  2*BITS  {HI, LO}; held from `done` until the next accept.
- `busy`  out  1  high from the accept edge until `done` is asserted.
- `done`  out  1  one-cycle pulse; result valid.
- `div_by_zero`  out  1  sticky with the result; set when a div has `Y`=0.
- `illegal_op`  out  1  sticky with the result; set when `ctrl_signal` is not exactly one-hot.

## Operation
- States: IDLE, MUL, DIV, DONE. `busy`=0 in IDLE and DONE.
- Accept: `start`=1 in IDLE or DONE. At that edge, latch X, Y and the opcode, and clear both flags.
- Single-cycle ops: go to DONE and load the result at the accept edge.
  - add: X+Y, carry dropped.
  - sub: X−Y.
  - and: X&Y, bitwise.
  - or: X|Y, bitwise.
  - neg: −X, two's complement.
  - not: ~X.
  - shr: logical right shift.
  - shl: left shift.
  - ror, rol: rotate.
  - Shift and rotate amount is Y[SHAMT_W-1:0]. A shift amount of 0 returns X.
  - For all single-cycle ops, HI = 0 and LO = the result.
- mul: signed × signed. The full 2*BITS product goes to {HI, LO}. Uses an iteration counter, then MUL → DONE.
- div: signed restoring divide, with quotient truncated toward zero. LO = quotient, HI = remainder, and the remainder carries the dividend's sign. Runs BITS iterations, then DIV → DONE.
- div boundary cases:
  - Y=0: no iteration; DONE at the next edge. LO = all ones, HI = X, `div_by_zero`=1.
  - X = most-negative and Y = −1: LO = X (wraps), HI = 0, no flag.
- Illegal opcode (zero bits or more than one bit set): DONE at the next edge, result 0, `illegal_op`=1.
- DONE lasts one cycle, then → IDLE unless a new start is accepted in that same cycle.
- `start` while `busy`=1: ignored, no queuing. Operands may change freely while busy.

## Timing
- Reset values: `operationResult`=0, `busy`=0, `done`=0, both flags 0, state IDLE, counter 0.
- `clr` has priority over `start` in the same cycle. `clr` mid-operation aborts the operation; no `done` is issued.
- Latency is counted in edges from the accept edge to the edge that raises `done`:
  - single-cycle ops, illegal op, and div-by-zero: 1
  - div: BITS+1
  - mul: BITS+1 (radix-2) or BITS/2+1 (radix-4)
- Back-to-back: a start accepted in the DONE cycle gives a 1-cycle issue interval for single-cycle ops.
- `operationResult` is registered and changes only at the edge that raises `done`, or on `clr`.

## Configuration
- `SEQ_ALU_BOOTH4_EN` defined: mul uses radix-4 Booth recoding, retiring 2 bits per cycle. Latency is BITS/2+1.
- Undefined: radix-2 shift-add signed multiply with a correction step for the sign bit. Latency is BITS+1.
- Results are bit-identical in both builds. The div path and all other ops are unaffected.

## Test plan
- add, X=0xFFFF_FFFF, Y=1 → `done` 1 edge after accept, result 0x0000_0000_0000_0000. rol, X=0x8000_0001, Y=4 → LO=0x0000_0018.
- mul, X=−3 (0xFFFF_FFFD), Y=7 → result 0xFFFF_FFFF_FFFF_FFEB.
  - `done` at edge 33 without the macro, edge 17 with it.
  - `busy` high throughout.
  - A `start` pulsed mid-op is ignored.
- div, X=−7, Y=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF, `done` at edge 33. X=0x8000_0000, Y=−1 → LO=0x8000_0000, HI=0.
- div, Y=0, X=0x1234 → next-edge `done`, LO=0xFFFF_FFFF, HI=0x1234, `div_by_zero`=1. The next accepted add clears the flag.
- `ctrl_signal`=0x003 → `illegal_op`=1, result 0. `ctrl_signal`=0 → same response.
- `clr` asserted at edge 10 of a div → no `done`, all outputs 0 next cycle. `clr`+`start` in the same cycle → stays IDLE.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/shift/rotate ops, iterative signed multiply and divide.
// Define SEQ_ALU_BOOTH4_EN for a radix-4 Booth multiplier; otherwise radix-2 shift-add.
module seq_alu #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 12,
    parameter int SHAMT_W   = $clog2(BITS)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [SIG_COUNT-1:0]   ctrl_signal,
    input  logic [BITS-1:0]        X,
    input  logic [BITS-1:0]        Y,
    output logic [2*BITS-1:0]      operationResult,
    output logic                   busy,
    output logic                   done,
    output logic                   div_by_zero,
    output logic                   illegal_op
);

    localparam int W2    = 2 * BITS;
    localparam int CNT_W = SHAMT_W;
`ifdef SEQ_ALU_BOOTH4_EN
    localparam int STEP = 2;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(BITS / 2 - 1);
`else
    localparam int STEP = 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(BITS - 1);
`endif
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BITS - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_next;

    // Handshake: start is taken only while busy=0 (IDLE or DONE); busy stays high until the
    // edge that raises done; done is a one-cycle pulse marking operationResult and flags valid.
    logic                 accept, op_legal, op_mul, op_div, y_zero;
    logic [SHAMT_W-1:0]   shamt;
    logic [SHAMT_W:0]     inv_shamt;
    logic [BITS-1:0]      single_res, x_mag, y_mag;

    logic [CNT_W-1:0]     cnt;
    logic [W2-1:0]        acc, mcand, acc_next;
    logic [BITS:0]        mplier;
    logic [BITS-1:0]      rem, quo, dvsr;
    logic                 neg_q, neg_r;
    logic [BITS:0]        rem_shift, rem_diff;
    logic [BITS-1:0]      rem_next, quo_next, q_signed, r_signed;

    assign accept   = start && (state == IDLE || state == DONE);
    assign op_legal = (ctrl_signal != '0) &&
                      ((ctrl_signal & (ctrl_signal - SIG_COUNT'(1))) == '0);
    assign op_mul   = ctrl_signal[2];
    assign op_div   = ctrl_signal[3];
    assign y_zero   = (Y == '0);
    assign x_mag    = X[BITS-1] ? -X : X;
    assign y_mag    = Y[BITS-1] ? -Y : Y;

    always_comb begin
        shamt      = Y[SHAMT_W-1:0];
        inv_shamt  = (SHAMT_W+1)'(BITS) - {1'b0, shamt};
        single_res = '0;
        if (ctrl_signal[0])       single_res = X + Y;
        else if (ctrl_signal[1])  single_res = X - Y;
        else if (ctrl_signal[4])  single_res = X >> shamt;
        else if (ctrl_signal[5])  single_res = X << shamt;
        // A shift by the full width yields 0, so a zero amount leaves X unchanged.
        else if (ctrl_signal[6])  single_res = (X >> shamt) | (X << inv_shamt);
        else if (ctrl_signal[7])  single_res = (X << shamt) | (X >> inv_shamt);
        else if (ctrl_signal[8])  single_res = X & Y;
        else if (ctrl_signal[9])  single_res = X | Y;
        else if (ctrl_signal[10]) single_res = -X;
        else if (ctrl_signal[11]) single_res = ~X;
    end

    always_comb begin
        acc_next = acc;
`ifdef SEQ_ALU_BOOTH4_EN
        case (mplier[2:0])
            3'b001, 3'b010: acc_next = acc + mcand;
            3'b011:         acc_next = acc + (mcand << 1);
            3'b100:         acc_next = acc - (mcand << 1);
            3'b101, 3'b110: acc_next = acc - mcand;
            default:        acc_next = acc;
        endcase
`else
        // The multiplier's sign bit carries negative weight, hence the final subtract.
        if (mplier[0])
            acc_next = (cnt == MUL_LAST) ? acc - mcand : acc + mcand;
`endif
    end

    always_comb begin
        rem_shift = {rem, quo[BITS-1]};
        rem_diff  = rem_shift - {1'b0, dvsr};
        if (!rem_diff[BITS]) begin
            rem_next = rem_diff[BITS-1:0];
            quo_next = {quo[BITS-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[BITS-1:0];
            quo_next = {quo[BITS-2:0], 1'b0};
        end
        q_signed = neg_q ? -quo_next : quo_next;
        r_signed = neg_r ? -rem_next : rem_next;
    end

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done       = (state == DONE);
                state_next = IDLE;
                if (accept) begin
                    if (!op_legal)              state_next = DONE;
                    else if (op_mul)            state_next = MUL;
                    else if (op_div && !y_zero) state_next = DIV;
                    else                        state_next = DONE;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (cnt == MUL_LAST) state_next = DONE;
            end
            DIV: begin
                busy = 1'b1;
                if (cnt == DIV_LAST) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            operationResult <= '0;
            div_by_zero     <= 1'b0;
            illegal_op      <= 1'b0;
            cnt             <= '0;
            acc             <= '0;
            mcand           <= '0;
            mplier          <= '0;
            rem             <= '0;
            quo             <= '0;
            dvsr            <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
        end else if (accept) begin
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            cnt         <= '0;
            if (!op_legal) begin
                operationResult <= '0;
                illegal_op      <= 1'b1;
            end else if (op_mul) begin
                acc   <= '0;
                mcand <= {{BITS{X[BITS-1]}}, X};
`ifdef SEQ_ALU_BOOTH4_EN
                mplier <= {Y, 1'b0};
`else
                mplier <= {1'b0, Y};
`endif
            end else if (op_div) begin
                if (y_zero) begin
                    operationResult <= {X, {BITS{1'b1}}};
                    div_by_zero     <= 1'b1;
                end else begin
                    rem   <= '0;
                    quo   <= x_mag;
                    dvsr  <= y_mag;
                    neg_q <= X[BITS-1] ^ Y[BITS-1];
                    neg_r <= X[BITS-1];
                end
            end else begin
                operationResult <= {{BITS{1'b0}}, single_res};
            end
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << STEP;
            mplier <= mplier >> STEP;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == MUL_LAST) operationResult <= acc_next;
        end else if (state == DIV) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == DIV_LAST) operationResult <= {r_signed, q_signed};
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed and randomized bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
    localparam int BITS = 32;
`ifdef SEQ_ALU_BOOTH4_EN
    localparam int MUL_LAT = BITS / 2 + 1;
`else
    localparam int MUL_LAT = BITS + 1;
`endif
    localparam int DIV_LAT = BITS + 1;

    logic        clk = 1'b0;
    logic        clr, start;
    logic [11:0] ctrl_signal;
    logic [31:0] X, Y;
    logic [63:0] operationResult;
    logic        busy, done, div_by_zero, illegal_op;

    int compared   = 0;
    int mismatched = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res;
    logic        last_dbz, last_ill;

    seq_alu #(.BITS(BITS), .SIG_COUNT(12)) dut (
        .clk(clk), .clr(clr), .start(start), .ctrl_signal(ctrl_signal),
        .X(X), .Y(Y), .operationResult(operationResult),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [11:0] c, input logic [31:0] x, input logic [31:0] y,
                                  output logic [63:0] r, output logic dbz, output logic ill,
                                  output int lat);
        longint sx, sy, q, rm, p;
        int s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        s  = int'(y[4:0]);
        r = '0; dbz = 1'b0; ill = 1'b0; lat = 1;
        if ($countones(c) != 1) begin
            ill = 1'b1;
            return;
        end
        case (c)
            12'h001: r = {32'h0, 32'(x + y)};
            12'h002: r = {32'h0, 32'(x - y)};
            12'h004: begin p = sx * sy; r = p; lat = MUL_LAT; end
            12'h008: begin
                if (y == 32'h0) begin
                    r = {x, 32'hFFFF_FFFF};
                    dbz = 1'b1;
                end else begin
                    q  = sx / sy;
                    rm = sx % sy;
                    r  = {rm[31:0], q[31:0]};
                    lat = DIV_LAT;
                end
            end
            12'h010: r = {32'h0, x >> s};
            12'h020: r = {32'h0, x << s};
            12'h040: r = {32'h0, (x >> s) | (x << (32 - s))};
            12'h080: r = {32'h0, (x << s) | (x >> (32 - s))};
            12'h100: r = {32'h0, x & y};
            12'h200: r = {32'h0, x | y};
            12'h400: r = {32'h0, 32'(-x)};
            12'h800: r = {32'h0, ~x};
            default: r = '0;
        endcase
    endfunction

    // Issues one operation at the next falling edge and follows it to done.
    task automatic run_op(input string tag, input logic [11:0] c, input logic [31:0] x,
                          input logic [31:0] y, input bit poke);
        logic [63:0] er;
        logic ed, ei;
        int lat, edges;
        model(c, x, y, er, ed, ei, lat);
        exp_q.push_back(er);
        @(negedge clk);
        start = 1'b1; ctrl_signal = c; X = x; Y = y;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            start = 1'b0;
            X = $urandom; Y = $urandom; ctrl_signal = 12'($urandom);
            if (!done) begin
                check({tag, " busy"}, 64'(busy), 64'(1));
                if (poke && (edges % 5 == 0)) start = 1'b1;
            end
        end while (!done && edges < 100);
        check({tag, " latency"}, 64'(edges), 64'(lat));
        check({tag, " result"}, operationResult, exp_q.pop_front());
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ed));
        check({tag, " illegal_op"}, 64'(illegal_op), 64'(ei));
        check({tag, " busy at done"}, 64'(busy), 64'(0));
        last_res = er; last_dbz = ed; last_ill = ei;
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 64'(done), 64'(0));
        check({tag, " held result"}, operationResult, last_res);
        check({tag, " held dbz"}, 64'(div_by_zero), 64'(last_dbz));
        check({tag, " held ill"}, 64'(illegal_op), 64'(last_ill));
    endtask

    initial begin
        int edges, done_seen, sel;
        logic [11:0] c;
        logic [31:0] rx, ry;

        clr = 1'b1; start = 1'b0; ctrl_signal = '0; X = '0; Y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", operationResult, 64'h0);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset dbz", 64'(div_by_zero), 64'(0));
        check("reset ill", 64'(illegal_op), 64'(0));
        @(negedge clk);
        clr = 1'b0;

        run_op("add wrap", 12'h001, 32'hFFFF_FFFF, 32'h1, 1'b0);
        check("add wrap const", operationResult, 64'h0);
        run_op("rol", 12'h080, 32'h8000_0001, 32'd4, 1'b0);
        check("rol const", operationResult, 64'h18);
        run_op("ror zero amt", 12'h040, 32'hDEAD_BEEF, 32'h20, 1'b0);
        run_op("mul", 12'h004, 32'hFFFF_FFFD, 32'd7, 1'b1);
        check("mul const", operationResult, 64'hFFFF_FFFF_FFFF_FFEB);
        idle_cycle("after mul");
        run_op("div neg", 12'h008, 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("div neg const", operationResult, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div min", 12'h008, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div min const", operationResult, 64'h0000_0000_8000_0000);
        run_op("div zero", 12'h008, 32'h1234, 32'h0, 1'b0);
        check("div zero const", operationResult, 64'h0000_1234_FFFF_FFFF);
        idle_cycle("after div zero");
        run_op("add clears", 12'h001, 32'd5, 32'd6, 1'b0);
        run_op("illegal 3", 12'h003, 32'h55, 32'h66, 1'b0);
        run_op("illegal 0", 12'h000, 32'h55, 32'h66, 1'b0);
        run_op("add before clr", 12'h001, 32'd5, 32'd6, 1'b0);

        // Abort a divide with clr on the 10th edge counted from accept.
        @(negedge clk);
        start = 1'b1; ctrl_signal = 12'h008; X = 32'd100; Y = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        while (edges < 9) begin
            @(posedge clk);
            edges++;
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr abort result", operationResult, 64'h0);
        check("clr abort busy", 64'(busy), 64'(0));
        check("clr abort done", 64'(done), 64'(0));
        check("clr abort flags", 64'({div_by_zero, illegal_op}), 64'(0));
        @(negedge clk);
        clr = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("clr no done", 64'(done_seen), 64'(0));

        @(negedge clk);
        clr = 1'b1; start = 1'b1; ctrl_signal = 12'h004; X = 32'd9; Y = 32'd9;
        @(posedge clk);
        #1;
        check("clr+start busy", 64'(busy), 64'(0));
        check("clr+start done", 64'(done), 64'(0));
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        check("clr+start idle", 64'({busy, done}), 64'(0));
        last_res = '0; last_dbz = 1'b0; last_ill = 1'b0;

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 12);
            if (sel == 12) begin
                c = 12'($urandom);
                if ($countones(c) == 1) c = '0;
            end else begin
                c = 12'(1) << sel;
            end
            case ($urandom_range(0, 7))
                0: rx = 32'h0;
                1: rx = 32'h8000_0000;
                2: rx = 32'hFFFF_FFFF;
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: ry = 32'h0;
                1: ry = 32'hFFFF_FFFF;
                2: ry = 32'(($urandom_range(0, 1) == 1) ? 1 : 31);
                default: ry = $urandom;
            endcase
            run_op("random", c, rx, ry, 1'($urandom_range(0, 1)));
            if (i % 10 == 9) idle_cycle("random idle");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
